// File: rtl/count_pkg.sv
// Shared definitions for the counter library: run-state encoding and default width.
package count_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/count_down_core.sv
// Datapath of the down-counter: count register with async clear, load mux,
// guarded decrement and a "count is one" detect used to spot the terminal edge.
module count_down_core
  import count_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             is_one
);

  // Count register: load wins over decrement; decrement never wraps below zero.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  // Terminal detect: the next enabled edge in RUN is the terminal edge.
  assign is_one = (cnt == WIDTH'(1));

endmodule

// File: rtl/count_down_timer.sv
// Loadable down-counter/timer with one-shot or auto-reload operation, a
// registered one-cycle terminal-count pulse and an IDLE/RUN/DONE run-state FSM.
// The state register is exposed on state_dbg for checker binding.
module count_down_timer
  import count_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic             load,
  input  logic [WIDTH-1:0] CNT_In,
  input  logic             reload,
  output logic [WIDTH-1:0] CNT,
  output logic             TC,
  output logic             busy,
  output logic             done,
  output state_e           state_dbg
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] rld_q;
  logic             is_one;
  logic             terminal;
  logic             core_load;
  logic [WIDTH-1:0] core_val;
  logic             core_dec;

  // Terminal edge: enabled edge in RUN while the count shows one and no load.
  assign terminal  = (state_q == RUN) && EN && !load && is_one;
  // A user load or a periodic terminal edge both go through the core's load path.
  assign core_load = load || (terminal && reload);
  assign core_val  = load ? CNT_In : rld_q;
  // One-shot terminal edge is a plain decrement from one to zero.
  assign core_dec  = (state_q == RUN) && EN && !load && !(terminal && reload);

  count_down_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .res      (res),
    .load     (core_load),
    .load_val (core_val),
    .dec      (core_dec),
    .cnt      (CNT),
    .is_one   (is_one)
  );

  // Next-state logic: load decides RUN/DONE from the load value; a one-shot
  // terminal edge ends in DONE; otherwise the state holds.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (CNT_In != '0) ? RUN : DONE;
    end else if (terminal && !reload) begin
      state_d = DONE;
    end
  end

  // State, reload value and terminal-count pulse registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      rld_q   <= '0;
      TC      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        rld_q <= CNT_In;
      end
      TC <= terminal;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_count_down_timer.sv
// Self-checking bench for count_down_timer: directed scenarios plus a random
// run, each compared against a behavioural model of the timer's rules.
module tb_count_down_timer;
  import count_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic         en = 1'b0;
  logic         ld = 1'b0;
  logic [W-1:0] cnt_in = '0;
  logic         rl = 1'b0;
  logic [W-1:0] cnt;
  logic         tc;
  logic         busy;
  logic         done;
  state_e       state_dbg;

  always #20 clk = ~clk;

  count_down_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .res       (res),
    .EN        (en),
    .load      (ld),
    .CNT_In    (cnt_in),
    .reload    (rl),
    .CNT       (cnt),
    .TC        (tc),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  // Model run mode: 0 idle, 1 running, 2 finished.
  int           m_mode = 0;
  logic [W-1:0] m_cnt  = '0;
  logic [W-1:0] m_rld  = '0;
  logic         m_tc   = 1'b0;

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = '0;
    m_rld  = '0;
    m_tc   = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [W-1:0] v, input logic r);
    m_tc = 1'b0;
    if (l) begin
      m_cnt  = v;
      m_rld  = v;
      m_mode = (v != 0) ? 1 : 2;
    end else if (m_mode == 1 && e) begin
      if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end else begin
        m_tc = 1'b1;
        if (r) m_cnt = m_rld;
        else begin
          m_cnt  = 0;
          m_mode = 2;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs on the falling edge, advance the model on the rising edge,
  // leave time positioned 1 ns after the rising edge for sampling.
  task automatic tick(input logic e, input logic l, input logic [W-1:0] v, input logic r);
    @(negedge clk);
    en = e; ld = l; cnt_in = v; rl = r;
    @(posedge clk);
    model_edge(e, l, v, r);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    res = 1'b1;
    repeat (2) tick(1'b1, 1'b1, 8'h33, 1'b0);
    model_reset();
    total++;
    if (cnt !== 8'h00 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_held cnt=%h tc=%b busy=%b done=%b want 00/0/0/0", cnt, tc, busy, done);
    end
    @(negedge clk);
    res = 1'b0;
    // Get into RUN first so the asynchronous reset has something to clear.
    tick(1'b0, 1'b1, 8'h09, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    #10;
    res = 1'b1;
    #1;
    model_reset();
    total++;
    if (cnt !== 8'h00 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_async cnt=%h tc=%b busy=%b done=%b want 00/0/0/0", cnt, tc, busy, done);
    end
    @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 8'h44, 1'b0);
      total++;
      if (cnt !== 8'h00 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL idle_en_no_effect i=%0d cnt=%h tc=%b busy=%b done=%b", i, cnt, tc, busy, done);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_c [6];
    logic         exp_t [6];
    exp_c = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tick(1'b1, 1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick(1'b1, 1'b0, 8'h77, 1'b0);
      total++;
      if (cnt !== exp_c[i] || tc !== exp_t[i] || cnt !== m_cnt || tc !== m_tc ||
          done !== (i >= 3) || busy !== (i < 3)) begin
        bad++;
        $display("FAIL one_shot i=%0d cnt=%h tc=%b busy=%b done=%b want cnt=%h tc=%b",
                 i, cnt, tc, busy, done, exp_c[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_periodic();
    logic [W-1:0] exp_c [5];
    logic         exp_t [5];
    exp_c = '{8'h02, 8'h01, 8'h02, 8'h01, 8'h02};
    exp_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tick(1'b1, 1'b1, 8'h02, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick(1'b1, 1'b0, 8'h00, 1'b1);
      total++;
      if (cnt !== exp_c[i] || tc !== exp_t[i] || busy !== 1'b1 || done !== 1'b0 ||
          cnt !== m_cnt || tc !== m_tc) begin
        bad++;
        $display("FAIL periodic i=%0d cnt=%h tc=%b busy=%b want cnt=%h tc=%b busy=1",
                 i, cnt, tc, busy, exp_c[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_hold_and_priority();
    tick(1'b1, 1'b1, 8'h08, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0);
    total++;
    if (cnt !== 8'h05 || cnt !== m_cnt) begin
      bad++;
      $display("FAIL reach_05 cnt=%h want 05", cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      total++;
      if (cnt !== 8'h05 || tc !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL en_hold i=%0d cnt=%h tc=%b busy=%b want 05/0/1", i, cnt, tc, busy);
      end
    end
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    total++;
    if (cnt !== 8'h04) begin
      bad++;
      $display("FAIL en_resume cnt=%h want 04", cnt);
    end
    tick(1'b1, 1'b1, 8'h11, 1'b0);
    total++;
    if (cnt !== 8'h11 || tc !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL load_over_en cnt=%h tc=%b want 11/0", cnt, tc);
    end
    tick(1'b1, 1'b1, 8'h00, 1'b0);
    total++;
    if (cnt !== 8'h00 || tc !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL load_zero cnt=%h tc=%b done=%b busy=%b want 00/0/1/0", cnt, tc, done, busy);
    end
  endtask

  task automatic test_reset_mid_run_and_full_load();
    int n;
    bit seen;
    tick(1'b1, 1'b1, 8'h09, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    #5;
    res = 1'b1;
    #4;
    res = 1'b0;
    #1;
    model_reset();
    total++;
    if (cnt !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0 || state_dbg !== IDLE) begin
      bad++;
      $display("FAIL reset_pulse cnt=%h busy=%b done=%b tc=%b want 00/0/0/0", cnt, busy, done, tc);
    end
    tick(1'b1, 1'b1, 8'hFF, 1'b0);
    n = 0;
    seen = 0;
    while (!seen && n < 300) begin
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      n++;
      if (tc === 1'b1) seen = 1;
    end
    total++;
    if (!seen || n != 255 || cnt !== 8'h00 || done !== 1'b1) begin
      bad++;
      $display("FAIL full_load_latency edges=%0d seen=%0d cnt=%h want edges=255 cnt=00", n, seen, cnt);
    end
  endtask

  task automatic test_random();
    logic         e, l, r;
    logic [W-1:0] v;
    int           errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       v = 8'h00;
        1:       v = 8'h01;
        default: v = W'($urandom_range(2, 6));
      endcase
      tick(e, l, v, r);
      total++;
      if (cnt !== m_cnt || tc !== m_tc || busy !== (m_mode == 1) || done !== (m_mode == 2)) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL random i=%0d cnt=%h tc=%b busy=%b done=%b want cnt=%h tc=%b mode=%0d",
                   i, cnt, tc, busy, done, m_cnt, m_tc, m_mode);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_hold_and_priority();
    test_reset_mid_run_and_full_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
